mpmc10_strip_rd_ctrl: RTL and testbench

Sequences a multi-strip cache-load read for one mpmc10 port.
- Accepts a load request (base address, strip count) and issues one memory read command per strip on the app_* command interface.
- Counts returned strips and drives the preset/strip-count/valid controls consumed by the cache write-address generator.
- Gates the cache write enable so surplus read data is ignored.
- Sits between the port arbiter and the DDR app interface, alongside the cache and its address generator.

---
 rtl/mpmc10_strip_rd_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mpmc10_strip_rd_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_strip_rd_ctrl.sv
// Multi-strip cache-load read sequencer for one mpmc10 port.
// Latency: ack 1 cycle after req, first read command 2 cycles after req, done 1 cycle after final strip.
// Backpressure: app_rdy low holds app_en/app_addr stable; surplus read data is dropped via cache_we.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req, req_addr, req_num_strips, ack, busy - load request handshake (req sampled in IDLE only)
//   app_en, app_cmd, app_addr, app_rdy, app_rd_data_valid - DDR app command / read-return interface
//   preset, addr_base, num_strips, strip_cnt, cache_we     - controls for the cache write-address generator
//   done, err                 - one-cycle completion / timeout pulses
module mpmc10_strip_rd_ctrl #(
    parameter int WID     = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic [5:0]  req_num_strips,
    output logic        ack,
    output logic        busy,
    output logic        app_en,
    output logic [2:0]  app_cmd,
    output logic [31:0] app_addr,
    input  logic        app_rdy,
    input  logic        app_rd_data_valid,
    output logic        preset,
    output logic [31:0] addr_base,
    output logic [5:0]  num_strips,
    output logic [5:0]  strip_cnt,
    output logic        cache_we,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESET,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_DONE
    } state_t;

    // Byte stride between strips: 16 bytes for 128-bit strips, 32 bytes otherwise.
    localparam int              SHIFT      = (WID == 128) ? 4 : 5;
    localparam logic [31:0]     ALIGN_MASK = ~((32'd1 << SHIFT) - 32'd1);
    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE     = WD_W'(1);

    state_t         state_q;
    logic           ack_q;
    logic           busy_q;
    logic           app_en_q;
    logic [31:0]    app_addr_q;
    logic           preset_q;
    logic [31:0]    addr_base_q;
    logic [5:0]     num_strips_q;
    logic [5:0]     strip_cnt_q;
    logic [5:0]     req_cnt_q;
    logic           done_q;
    logic           err_q;
    logic [WD_W-1:0] wd_q;

    logic [31:0]    app_addr_d;
    logic           last_cmd;
    logic           last_data;
    logic           data_window;

    // Address of the command following the one currently presented.
    assign app_addr_d  = addr_base_q + ({26'd0, req_cnt_q + 6'd1} << SHIFT);
    assign last_cmd    = (req_cnt_q == num_strips_q);
    assign last_data   = (strip_cnt_q == num_strips_q);
    assign data_window = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            app_en_q     <= 1'b0;
            app_addr_q   <= 32'd0;
            preset_q     <= 1'b0;
            addr_base_q  <= 32'd0;
            num_strips_q <= 6'd0;
            strip_cnt_q  <= 6'd0;
            req_cnt_q    <= 6'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            // Single-cycle pulses default low.
            ack_q    <= 1'b0;
            preset_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_base_q  <= req_addr & ALIGN_MASK;
                        num_strips_q <= req_num_strips;
                        ack_q        <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_PRESET;
                    end
                end

                ST_PRESET: begin
                    preset_q    <= 1'b1;
                    strip_cnt_q <= 6'd0;
                    req_cnt_q   <= 6'd0;
                    wd_q        <= '0;
                    app_en_q    <= 1'b1;
                    app_addr_q  <= addr_base_q;
                    state_q     <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (app_en_q && app_rdy) begin
                        req_cnt_q <= req_cnt_q + 6'd1;
                        if (last_cmd) begin
                            app_en_q <= 1'b0;
                            wd_q     <= '0;
                            state_q  <= ST_WAIT_DATA;
                        end else begin
                            app_addr_q <= app_addr_d;
                        end
                    end
                    // Final strip can only land here alongside the last command
                    // acceptance; it overrides the move to WAIT_DATA.
                    if (app_rd_data_valid) begin
                        if (last_data) begin
                            app_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            strip_cnt_q <= strip_cnt_q + 6'd1;
                        end
                    end
                end

                ST_WAIT_DATA: begin
                    if (app_rd_data_valid) begin
                        wd_q <= '0;
                        if (last_data) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            strip_cnt_q <= strip_cnt_q + 6'd1;
                        end
                    end else if (wd_q == WD_LAST) begin
                        // TIMEOUT valid-free cycles have now elapsed; err shows
                        // together with the watchdog reaching TIMEOUT.
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        wd_q    <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q   <= 1'b0;
                    app_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign app_en     = app_en_q;
    assign app_cmd    = 3'b001;
    assign app_addr   = app_addr_q;
    assign preset     = preset_q;
    assign addr_base  = addr_base_q;
    assign num_strips = num_strips_q;
    assign strip_cnt  = strip_cnt_q;
    assign done       = done_q;
    assign err        = err_q;
    // Only strips belonging to an active load reach the cache.
    assign cache_we   = app_rd_data_valid && data_window;

endmodule

// File: tb/tb_mpmc10_strip_rd_ctrl.sv
// Self-checking bench for mpmc10_strip_rd_ctrl: 256-bit and 128-bit instances share stimulus.
// Expected command addresses are queued when a load is requested and popped on each accepted command.
// A simple memory model returns one beat 4 cycles after each accepted command.
module tb_mpmc10_strip_rd_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] req_addr;
    logic [5:0]  req_num_strips;
    logic        app_rdy;
    logic        app_rd_data_valid;

    logic        a_ack, a_busy, a_app_en, a_preset, a_cache_we, a_done, a_err;
    logic [2:0]  a_app_cmd;
    logic [31:0] a_app_addr, a_addr_base;
    logic [5:0]  a_num_strips, a_strip_cnt;

    logic        b_ack, b_busy, b_app_en, b_preset, b_cache_we, b_done, b_err;
    logic [2:0]  b_app_cmd;
    logic [31:0] b_app_addr, b_addr_base;
    logic [5:0]  b_num_strips, b_strip_cnt;

    always #5 clk = ~clk;

    mpmc10_strip_rd_ctrl #(.WID(256), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_num_strips(req_num_strips),
        .ack(a_ack), .busy(a_busy), .app_en(a_app_en), .app_cmd(a_app_cmd), .app_addr(a_app_addr),
        .app_rdy(app_rdy), .app_rd_data_valid(app_rd_data_valid), .preset(a_preset),
        .addr_base(a_addr_base), .num_strips(a_num_strips), .strip_cnt(a_strip_cnt),
        .cache_we(a_cache_we), .done(a_done), .err(a_err)
    );

    mpmc10_strip_rd_ctrl #(.WID(128), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_num_strips(req_num_strips),
        .ack(b_ack), .busy(b_busy), .app_en(b_app_en), .app_cmd(b_app_cmd), .app_addr(b_app_addr),
        .app_rdy(app_rdy), .app_rd_data_valid(app_rd_data_valid), .preset(b_preset),
        .addr_base(b_addr_base), .num_strips(b_num_strips), .strip_cnt(b_strip_cnt),
        .cache_we(b_cache_we), .done(b_done), .err(b_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and memory-model state
    int          cyc = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          due_q[$];
    int          extra_q[$];
    int          beats_left;
    int          extra_beats;
    int          stall_idx;
    int          stall_left;
    int          stall_seen;
    int          cmd_cnt, we_cnt, done_cnt, err_cnt;
    int          last_valid_cyc, last_we_cyc;
    int          ack_cycs[$], preset_cycs[$], done_cycs[$], err_cycs[$];

    task automatic clear_stats();
        exp_a.delete(); exp_b.delete(); due_q.delete(); extra_q.delete();
        ack_cycs.delete(); preset_cycs.delete(); done_cycs.delete(); err_cycs.delete();
        beats_left = 1000; extra_beats = 0; stall_idx = -1; stall_left = 0; stall_seen = 0;
        cmd_cnt = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0;
        last_valid_cyc = -1; last_we_cyc = -1;
    endtask

    // One clock cycle: drive inputs, sample outputs 1 time unit later, advance past the edge.
    task automatic tick();
        bit surplus;
        surplus = 1'b0;
        app_rd_data_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            if (beats_left > 0) begin
                beats_left--;
                app_rd_data_valid = 1'b1;
            end
        end
        if (extra_q.size() > 0 && extra_q[0] == cyc) begin
            void'(extra_q.pop_front());
            app_rd_data_valid = 1'b1;
            surplus = 1'b1;
        end
        app_rdy = 1'b1;
        if (a_app_en === 1'b1 && cmd_cnt == stall_idx && stall_left > 0) begin
            app_rdy = 1'b0;
            stall_left--;
        end
        #1;
        if (app_rd_data_valid) last_valid_cyc = cyc;
        if (surplus) check("surplus_we", 32'(a_cache_we), 32'd0);
        if (a_cache_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (a_app_en === 1'b1 && !app_rdy) begin
            stall_seen++;
            check("stall_addr", a_app_addr, (exp_a.size() > 0) ? exp_a[0] : 32'hdead_beef);
        end
        if (a_app_en === 1'b1 && app_rdy) begin
            check("cmd_expected", 32'(exp_a.size() != 0), 32'd1);
            check("cmd_cmd", 32'(a_app_cmd), 32'd1);
            check("cmd_en_128", 32'(b_app_en), 32'd1);
            if (exp_a.size() != 0) begin
                check("cmd_addr_256", a_app_addr, exp_a.pop_front());
                if (exp_b.size() != 0) check("cmd_addr_128", b_app_addr, exp_b.pop_front());
                if (exp_a.size() == 0) begin
                    for (int k = 0; k < extra_beats; k++) extra_q.push_back(cyc + 5 + k);
                end
            end
            cmd_cnt++;
            due_q.push_back(cyc + 4);
        end
        if (a_preset === 1'b1) begin
            preset_cycs.push_back(cyc);
            check("strip_cnt_at_preset", 32'(a_strip_cnt), 32'd0);
        end
        if (a_ack === 1'b1) ack_cycs.push_back(cyc);
        if (a_done === 1'b1) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            check("busy_in_done", 32'(a_busy), 32'd1);
        end
        if (a_err === 1'b1) begin
            err_cnt++;
            err_cycs.push_back(cyc);
            check("busy_at_err", 32'(a_busy), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input logic [31:0] addr, input int n);
        for (int i = 0; i <= n; i++) begin
            exp_a.push_back((addr & 32'hffff_ffe0) + 32'(i * 32));
            exp_b.push_back((addr & 32'hffff_fff0) + 32'(i * 16));
        end
    endtask

    task automatic start_load(input logic [31:0] addr, input int n);
        push_exp(addr, n);
        req            = 1'b1;
        req_addr       = addr;
        req_num_strips = 6'(n);
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int ndone, input int budget);
        int t;
        t = 0;
        while (done_cnt < ndone && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(done_cnt >= ndone), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rst_cyc;
        int t;
        rst = 1'b1; req = 1'b0; req_addr = 32'd0; req_num_strips = 6'd0;
        app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        clear_stats();
        @(posedge clk); #1;
        tick(); tick();

        // Reset state
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_app_en", 32'(a_app_en), 32'd0);
        check("rst_app_cmd", 32'(a_app_cmd), 32'd1);
        check("rst_app_addr", a_app_addr, 32'd0);
        check("rst_addr_base", a_addr_base, 32'd0);
        check("rst_num_strips", 32'(a_num_strips), 32'd0);
        check("rst_strip_cnt", 32'(a_strip_cnt), 32'd0);
        check("rst_pulses", 32'({a_ack, a_preset, a_done, a_err, a_cache_we}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: four strips, memory always ready
        clear_stats();
        start_load(32'h0000_1234, 3);
        wait_done("t1_done", 1, 100);
        drain(6);
        check("t1_cmds", 32'(cmd_cnt), 32'd4);
        check("t1_we", 32'(we_cnt), 32'd4);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_ack_cnt", 32'(ack_cycs.size()), 32'd1);
        check("t1_preset_cnt", 32'(preset_cycs.size()), 32'd1);
        if (ack_cycs.size() == 1 && preset_cycs.size() == 1)
            check("t1_preset_after_ack", 32'(preset_cycs[0]), 32'(ack_cycs[0] + 1));
        if (done_cycs.size() > 0)
            check("t1_done_after_we", 32'(done_cycs[0]), 32'(last_we_cyc + 1));
        check("t1_strip_cnt", 32'(a_strip_cnt), 32'd3);
        check("t1_num_strips", 32'(a_num_strips), 32'd3);
        check("t1_addr_base", a_addr_base, 32'h0000_1220);
        check("t1_busy_idle", 32'(a_busy), 32'd0);
        check("t1_exp_empty", 32'(exp_a.size()), 32'd0);

        // 2: 2nd command stalled for 5 cycles
        clear_stats();
        stall_idx = 1; stall_left = 5;
        start_load(32'h0000_1234, 3);
        wait_done("t2_done", 1, 100);
        drain(6);
        check("t2_stall_cycles", 32'(stall_seen), 32'd5);
        check("t2_cmds", 32'(cmd_cnt), 32'd4);
        check("t2_we", 32'(we_cnt), 32'd4);
        check("t2_exp_empty", 32'(exp_a.size()), 32'd0);

        // 3: single strip with a surplus beat
        clear_stats();
        extra_beats = 1;
        start_load(32'h0000_2000, 0);
        wait_done("t3_done", 1, 50);
        drain(6);
        check("t3_cmds", 32'(cmd_cnt), 32'd1);
        check("t3_we", 32'(we_cnt), 32'd1);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);
        check("t3_strip_cnt", 32'(a_strip_cnt), 32'd0);

        // 4: misaligned base, both strip widths
        clear_stats();
        start_load(32'h0000_100F, 1);
        wait_done("t4_done", 1, 50);
        drain(4);
        check("t4_cmds", 32'(cmd_cnt), 32'd2);
        check("t4_base_256", a_addr_base, 32'h0000_1000);
        check("t4_base_128", b_addr_base, 32'h0000_1000);
        check("t4_exp_empty_128", 32'(exp_b.size()), 32'd0);

        // 5: three strips requested, one returned -> watchdog
        clear_stats();
        beats_left = 1;
        start_load(32'h0000_3000, 2);
        t = 0;
        while (err_cnt == 0 && t < 100) begin
            tick();
            t++;
        end
        check("t5_err_seen", 32'(err_cnt), 32'd1);
        // err coincides with the watchdog reaching TIMEOUT, i.e. the cycle after
        // the TIMEOUT-th valid-free cycle.
        if (err_cycs.size() > 0)
            check("t5_err_time", 32'(err_cycs[0]), 32'(last_valid_cyc + TMO + 1));
        drain(4);
        check("t5_err_once", 32'(err_cnt), 32'd1);
        check("t5_done_cnt", 32'(done_cnt), 32'd0);
        check("t5_strip_cnt", 32'(a_strip_cnt), 32'd1);
        check("t5_busy", 32'(a_busy), 32'd0);
        check("t5_app_en", 32'(a_app_en), 32'd0);

        // 6: reset while issuing
        clear_stats();
        start_load(32'h0000_4000, 3);
        t = 0;
        while (cmd_cnt < 1 && t < 20) begin
            tick();
            t++;
        end
        check("t6_first_cmd", 32'(cmd_cnt), 32'd1);
        rst = 1'b1;
        stall_idx = 1; stall_left = 1;
        rst_cyc = cyc;
        tick();
        rst = 1'b0;
        check("t6_app_en", 32'(a_app_en), 32'd0);
        check("t6_busy", 32'(a_busy), 32'd0);
        check("t6_strip_cnt", 32'(a_strip_cnt), 32'd0);
        drain(8);
        check("t6_late_valid_seen", 32'(last_valid_cyc > rst_cyc), 32'd1);
        check("t6_we", 32'(we_cnt), 32'd0);
        check("t6_done_cnt", 32'(done_cnt), 32'd0);
        check("t6_cmds", 32'(cmd_cnt), 32'd1);

        // 7: req held high across completion starts a second load immediately
        clear_stats();
        push_exp(32'h0000_5000, 0);
        push_exp(32'h0000_5000, 0);
        req = 1'b1; req_addr = 32'h0000_5000; req_num_strips = 6'd0;
        t = 0;
        while (done_cnt < 2 && t < 80) begin
            tick();
            if (ack_cycs.size() >= 2) req = 1'b0;
            t++;
        end
        req = 1'b0;
        check("t7_done_cnt", 32'(done_cnt), 32'd2);
        check("t7_ack_cnt", 32'(ack_cycs.size()), 32'd2);
        if (ack_cycs.size() >= 2 && done_cycs.size() >= 1)
            check("t7_reaccept", 32'(ack_cycs[1]), 32'(done_cycs[0] + 2));
        drain(4);
        check("t7_cmds", 32'(cmd_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
